// File: rtl/snake_pkg.sv
// snake_pkg: shared grid geometry, cell-type codes and rect word field widths
package snake_pkg;
  localparam int GRID_SIZE_X = 32;
  localparam int GRID_SIZE_Y = 24;
  localparam int COORD_W = 16;
  localparam int TYPE_W = 4;
  localparam int ADDR_W = 10;
  localparam logic [TYPE_W-1:0] NULL = 4'b0000;
  localparam logic [TYPE_W-1:0] SNAKE = 4'b0001;
  localparam logic [TYPE_W-1:0] ROCK = 4'b0010;
  localparam logic [TYPE_W-1:0] SNACK = 4'b0100;
  typedef enum logic {CLEAR, READY} state_t;
endpackage

// File: rtl/grid_ram.sv
// grid_ram: 1024x4 cell memory, one write port, two synchronous read-before-write ports
module grid_ram #(
  parameter int AW = 10,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] qa,
  input  logic [AW-1:0] rb,
  output logic [DW-1:0] qb
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    qa <= mem[ra];
    qb <= mem[rb];
  end
endmodule

// File: rtl/rect_grid_store.sv
// rect_grid_store: snake playfield cell store with clear sweep, collision port and display port
module rect_grid_store #(
  parameter int GRID_SIZE_X = snake_pkg::GRID_SIZE_X,
  parameter int GRID_SIZE_Y = snake_pkg::GRID_SIZE_Y,
  parameter bit BORDER_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_req,
  input  logic [35:0] rect_write,
  input  logic [31:0] rect_read_in,
  output logic [3:0]  rect_read_out,
  input  logic [4:0]  disp_x,
  input  logic [4:0]  disp_y,
  output logic [3:0]  disp_type,
  output logic        ready
);
  import snake_pkg::*;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(GRID_SIZE_Y * 32 - 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] idx, idx_nx, waddr, raddr, daddr;
  logic [COORD_W-1:0] wx, wy, rx, ry;
  logic [TYPE_W-1:0] wt, wdata, ram_r, ram_d, byp_type;
  logic w_ok, r_ok, border, we, r_null, r_rock, r_byp, d_null;
  assign {wx, wy, wt} = rect_write;
  assign {rx, ry} = rect_read_in;
  always_comb begin
    state_nx = clear_req ? CLEAR : (state == CLEAR && idx == LAST) ? READY : state;
    idx_nx = (clear_req || state == READY || idx == LAST) ? '0 : idx + 1'b1;
    border = BORDER_EN && (idx[4:0] == 5'd0 || idx[4:0] == 5'(GRID_SIZE_X - 1) ||
                           idx[9:5] == 5'd0 || idx[9:5] == 5'(GRID_SIZE_Y - 1));
    w_ok = wx < COORD_W'(GRID_SIZE_X) && wy < COORD_W'(GRID_SIZE_Y);
    r_ok = rx < COORD_W'(GRID_SIZE_X) && ry < COORD_W'(GRID_SIZE_Y);
    we = state == CLEAR || w_ok;
    waddr = state == CLEAR ? idx : {wy[4:0], wx[4:0]};
    wdata = state == CLEAR ? (border ? ROCK : NULL) : wt;
    raddr = {ry[4:0], rx[4:0]};
    daddr = {disp_y, disp_x};
    ready = state == READY;
    rect_read_out = r_null ? NULL : r_rock ? ROCK : r_byp ? byp_type : ram_r;
    disp_type = d_null ? NULL : ram_d;
  end
  // RAM outputs carry no reset, so masking flags reset to "force NULL"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      idx <= '0;
      r_null <= 1'b1;
      r_rock <= 1'b0;
      r_byp <= 1'b0;
      byp_type <= NULL;
      d_null <= 1'b1;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      r_null <= state == CLEAR;
      r_rock <= !r_ok;
      r_byp <= w_ok && raddr == {wy[4:0], wx[4:0]};
      byp_type <= wt;
      d_null <= state == CLEAR || disp_y >= 5'(GRID_SIZE_Y);
    end
  end
  grid_ram #(.AW(ADDR_W), .DW(TYPE_W)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .ra(raddr),
    .qa(ram_r),
    .rb(daddr),
    .qb(ram_d)
  );
endmodule
